// File: rtl/ddr2_v10_1_0002_read_valid_vfifo.sv
// rtl/ddr2_v10_1_0002_read_valid_vfifo.sv - per-DQS-group read-valid delay FIFO
// Delays each group's read enable by a calibrated, run-time adjustable offset.
module ddr2_v10_1_0002_read_valid_vfifo #(
  parameter int MEM_READ_DQS_WIDTH   = 2,
  parameter int READ_VALID_FIFO_SIZE = 16,
  parameter int VFIFO_PTR_WIDTH      = 4
) (
  input  logic                                          phy_clk,
  input  logic                                          phy_reset,
  input  logic [MEM_READ_DQS_WIDTH-1:0]                 afi_rdata_en,
  input  logic [MEM_READ_DQS_WIDTH-1:0]                 phy_read_increment_vfifo_fr,
  input  logic [MEM_READ_DQS_WIDTH-1:0]                 phy_read_increment_vfifo_hr,
  input  logic [MEM_READ_DQS_WIDTH-1:0]                 phy_read_fifo_reset,
  input  logic [MEM_READ_DQS_WIDTH-1:0]                 phy_vfifo_rd_en_override,
  input  logic                                          wrap_flag_clear,
  output logic [MEM_READ_DQS_WIDTH-1:0]                 read_valid,
  output logic [MEM_READ_DQS_WIDTH*VFIFO_PTR_WIDTH-1:0] vfifo_offset,
  output logic [MEM_READ_DQS_WIDTH-1:0]                 vfifo_wrap
);

  localparam int W = VFIFO_PTR_WIDTH;
  localparam int S = READ_VALID_FIFO_SIZE;

  logic [W-1:0] wr_ptr;

  // Shared write pointer; S is a power of two so natural rollover is modulo S.
  always_ff @(posedge phy_clk or posedge phy_reset) begin
    if (phy_reset) begin
      wr_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  for (genvar g = 0; g < MEM_READ_DQS_WIDTH; g++) begin : g_grp
    logic [S-1:0] hist_q;
    logic [W-1:0] offset_q;
    logic         wrap_q;
    logic         rv_q;
    logic [W-1:0] rd_tap;
    logic         tap_bit;
    logic [W:0]   inc;
    logic [W:0]   sum;

    // Offset 0 taps the bit being written this cycle, so take it straight from the input.
    always_comb begin
      rd_tap  = wr_ptr - offset_q;
      tap_bit = (offset_q == '0) ? afi_rdata_en[g] : hist_q[rd_tap];
      inc     = {{(W-1){1'b0}}, phy_read_increment_vfifo_hr[g], phy_read_increment_vfifo_fr[g]};
      sum     = {1'b0, offset_q} + inc;
    end

    always_ff @(posedge phy_clk or posedge phy_reset) begin
      if (phy_reset) begin
        hist_q   <= '0;
        offset_q <= '0;
        wrap_q   <= 1'b0;
        rv_q     <= 1'b0;
      end else begin
        if (phy_read_fifo_reset[g]) begin
          hist_q <= '0;
        end else begin
          hist_q[wr_ptr] <= afi_rdata_en[g];
        end
        if (phy_read_fifo_reset[g]) begin
          rv_q <= 1'b0;
        end else if (phy_vfifo_rd_en_override[g]) begin
          rv_q <= afi_rdata_en[g];
        end else begin
          rv_q <= tap_bit;
        end
        offset_q <= sum[W-1:0];
        // A wrap in the same cycle as a clear wins.
        wrap_q   <= sum[W] | (wrap_q & ~wrap_flag_clear);
      end
    end

    assign read_valid[g]            = rv_q;
    assign vfifo_wrap[g]            = wrap_q;
    assign vfifo_offset[g*W +: W]   = offset_q;
  end

endmodule

// File: tb/tb_ddr2_v10_1_0002_read_valid_vfifo.sv
// tb/tb_ddr2_v10_1_0002_read_valid_vfifo.sv - self-checking bench for the read-valid VFIFO
// Vector table, directed corner sequences and random stimulus against a cycle-history model.
module tb_ddr2_v10_1_0002_read_valid_vfifo;

  logic       phy_clk;
  logic       phy_reset;
  logic [1:0] afi_rdata_en;
  logic [1:0] fr, hr, frst, ovr;
  logic       clr;
  logic [1:0] read_valid;
  logic [7:0] vfifo_offset;
  logic [1:0] vfifo_wrap;

  ddr2_v10_1_0002_read_valid_vfifo dut (
    .phy_clk                     (phy_clk),
    .phy_reset                   (phy_reset),
    .afi_rdata_en                (afi_rdata_en),
    .phy_read_increment_vfifo_fr (fr),
    .phy_read_increment_vfifo_hr (hr),
    .phy_read_fifo_reset         (frst),
    .phy_vfifo_rd_en_override    (ovr),
    .wrap_flag_clear             (clr),
    .read_valid                  (read_valid),
    .vfifo_offset                (vfifo_offset),
    .vfifo_wrap                  (vfifo_wrap)
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  int nerr = 0;
  int nchk = 0;

  // Model: every cycle's enable is remembered by cycle number; a flush hides cycles <= its stamp.
  int cyc = 0;
  bit hist_m [2][0:8191];
  int lf [2];
  int off_m [2];
  bit wrap_m [2];
  bit rv_m [2];

  typedef struct {
    logic [1:0] fr, hr, frst, ovr, en;
    logic       clr;
    logic [1:0] rv;
    logic [7:0] off;
    logic [1:0] wrap;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int g = 0; g < 2; g++) begin
      int inc;
      hist_m[g][cyc] = afi_rdata_en[g];
      if (frst[g]) rv_m[g] = 1'b0;
      else if (ovr[g]) rv_m[g] = afi_rdata_en[g];
      else begin
        int src;
        src = cyc - off_m[g];
        rv_m[g] = (src > lf[g]) ? hist_m[g][src] : 1'b0;
      end
      if (frst[g]) lf[g] = cyc;
      inc = int'(fr[g]) + 2 * int'(hr[g]);
      wrap_m[g] = (off_m[g] + inc >= 16) || (wrap_m[g] && !clr);
      off_m[g] = (off_m[g] + inc) % 16;
    end
    cyc++;
  endtask

  task automatic tick();
    logic [3:0] o0, o1;
    @(posedge phy_clk);
    model_edge();
    #1;
    o0 = off_m[0][3:0];
    o1 = off_m[1][3:0];
    chk("model_rv", int'(read_valid), int'({rv_m[1], rv_m[0]}));
    chk("model_off", int'(vfifo_offset), int'({o1, o0}));
    chk("model_wrap", int'(vfifo_wrap), int'({wrap_m[1], wrap_m[0]}));
  endtask

  task automatic idle();
    afi_rdata_en = '0; fr = '0; hr = '0; frst = '0; ovr = '0; clr = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    phy_reset = 1'b1;
    idle();
    #1;
    chk("async_rst_rv", int'(read_valid), 0);
    chk("async_rst_off", int'(vfifo_offset), 0);
    chk("async_rst_wrap", int'(vfifo_wrap), 0);
    for (int g = 0; g < 2; g++) begin
      off_m[g] = 0; wrap_m[g] = 1'b0; rv_m[g] = 1'b0;
    end
    @(negedge phy_clk);
    @(negedge phy_clk);
    phy_reset = 1'b0;
    for (int g = 0; g < 2; g++) lf[g] = cyc - 1;
  endtask

  // One-cycle enable pulse on mask m; reports first latency and pulse count per group.
  task automatic pulse(input logic [1:0] m, output int l0, output int l1, output int c0, output int c1);
    l0 = -1; l1 = -1; c0 = 0; c1 = 0;
    afi_rdata_en = m;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) afi_rdata_en = '0;
      if (read_valid[0]) begin c0++; if (l0 < 0) l0 = k; end
      if (read_valid[1]) begin c1++; if (l1 < 0) l1 = k; end
    end
  endtask

  int l0, l1, c0, c1;

  initial begin
    phy_reset = 1'b1;
    idle();
    for (int g = 0; g < 2; g++) begin
      off_m[g] = 0; wrap_m[g] = 1'b0; rv_m[g] = 1'b0; lf[g] = -1;
    end
    #2;
    chk("reset_rv", int'(read_valid), 0);
    chk("reset_off", int'(vfifo_offset), 0);
    chk("reset_wrap", int'(vfifo_wrap), 0);
    @(negedge phy_clk);
    phy_reset = 1'b0;

    tbl[0]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0, 2'd3, 8'h00, 2'd0};
    tbl[1]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 2'd0};
    tbl[2]  = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h01, 2'd0};
    tbl[3]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0, 2'd2, 8'h01, 2'd0};
    tbl[4]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 8'h01, 2'd0};
    tbl[5]  = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h21, 2'd0};
    tbl[6]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 2'd1, 8'h21, 2'd0};
    tbl[7]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 8'h21, 2'd0};
    tbl[8]  = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 1'b0, 2'd0, 8'h21, 2'd0};
    tbl[9]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h21, 2'd0};
    tbl[10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h21, 2'd0};
    tbl[11] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h51, 2'd0};
    for (int i = 0; i < 12; i++) begin
      fr = tbl[i].fr; hr = tbl[i].hr; frst = tbl[i].frst; ovr = tbl[i].ovr;
      afi_rdata_en = tbl[i].en; clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_rv", i), int'(read_valid), int'(tbl[i].rv));
      chk($sformatf("tbl%0d_off", i), int'(vfifo_offset), int'(tbl[i].off));
      chk($sformatf("tbl%0d_wrap", i), int'(vfifo_wrap), int'(tbl[i].wrap));
    end
    idle();

    // Offset 0 on both groups: 1-cycle latency.
    do_reset();
    repeat (3) tick();
    pulse(2'b11, l0, l1, c0, c1);
    chk("lat0_g0", l0, 1); chk("lat0_g1", l1, 1); chk("lat0_cnt0", c0, 1); chk("lat0_cnt1", c1, 1);

    // Three fr pulses on group 0.
    fr = 2'b01;
    repeat (3) tick();
    fr = 2'b00;
    repeat (16) tick();
    chk("off3", int'(vfifo_offset[3:0]), 3);
    pulse(2'b11, l0, l1, c0, c1);
    chk("lat3_g0", l0, 4); chk("lat3_cnt0", c0, 1); chk("lat3_g1", l1, 1);

    // Wrap from offset 14 with fr+hr, clear, then clear colliding with a new wrap.
    do_reset();
    hr = 2'b10;
    repeat (7) tick();
    fr = 2'b10;
    tick();
    idle();
    chk("wrap_off1", int'(vfifo_offset[7:4]), 1);
    chk("wrap_flags", int'(vfifo_wrap), 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("wrap_clr", int'(vfifo_wrap), 0);
    hr = 2'b10;
    repeat (7) tick();
    hr = 2'b00; fr = 2'b10; clr = 1'b1;
    tick();
    idle();
    chk("wrap_beats_clr", int'(vfifo_wrap), 2);

    // Offset 5, 4-cycle burst flushed on its last cycle.
    do_reset();
    fr = 2'b01;
    repeat (5) tick();
    idle();
    repeat (16) tick();
    c0 = 0;
    afi_rdata_en = 2'b01;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) frst = 2'b01;
      if (k == 4) begin frst = 2'b00; afi_rdata_en = 2'b00; end
      tick();
      if (read_valid[0]) c0++;
    end
    chk("flush_none", c0, 0);
    chk("flush_off5", int'(vfifo_offset[3:0]), 5);
    pulse(2'b01, l0, l1, c0, c1);
    chk("flush_next_lat", l0, 6);

    // Override bypasses offset 7, then the programmed delay returns.
    do_reset();
    fr = 2'b01;
    repeat (7) tick();
    idle();
    ovr = 2'b01;
    tick();
    pulse(2'b01, l0, l1, c0, c1);
    chk("ovr_lat", l0, 1);
    ovr = 2'b00;
    repeat (16) tick();
    pulse(2'b01, l0, l1, c0, c1);
    chk("ovr_off_lat", l0, 8);

    // Reset mid-burst with offset 9.
    do_reset();
    fr = 2'b01;
    repeat (9) tick();
    idle();
    afi_rdata_en = 2'b11;
    repeat (12) tick();
    do_reset();
    pulse(2'b11, l0, l1, c0, c1);
    chk("post_rst_g0", l0, 1); chk("post_rst_g1", l1, 1);

    // Random stimulus against the model.
    for (int i = 0; i < 500; i++) begin
      afi_rdata_en = 2'($urandom);
      fr   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      hr   = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      frst = ($urandom_range(0, 29) == 0) ? 2'($urandom) : 2'b00;
      clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) ovr = 2'($urandom);
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
